// File: rtl/run_det_pkg.sv
// Shared mode constants and width helper for the run-length detector.
package run_det_pkg;

    localparam int unsigned DET_BOTH  = 0;
    localparam int unsigned DET_ONES  = 1;
    localparam int unsigned DET_ZEROS = 2;

    function automatic int unsigned run_cnt_w(input int unsigned run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Synchronous-reset up counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_detector_fsm.sv
// Run-length detector: z is high while the last RUN_LEN enabled samples match and MODE qualifies.
// Define RUN_DETECTOR_HIT_CNT_EN to build the saturating detection-event counter on hits.
module run_detector_fsm
    import run_det_pkg::*;
#(
    parameter  int unsigned RUN_LEN = 4,
    parameter  int unsigned MODE    = 0,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned CW      = run_cnt_w(RUN_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    output logic             z,
    output logic [CW:0]      states,
    output logic [CNT_W-1:0] hits
);

    localparam logic [CW-1:0] RunLenC = CW'(RUN_LEN);

    logic [CW-1:0] run_cnt_q, run_cnt_d;
    logic          run_bit_q, run_bit_d;
    logic          z_q, z_d;
    logic          mode_ok;

    always_comb begin
        run_cnt_d = run_cnt_q;
        run_bit_d = run_bit_q;
        mode_ok   = 1'b0;

        if (en) begin
            // A break restarts at RUN_1 because the breaking sample begins the new run.
            if ((run_cnt_q == '0) || (w != run_bit_q)) begin
                run_cnt_d = CW'(1);
                run_bit_d = w;
            end else if (run_cnt_q != RunLenC) begin
                run_cnt_d = run_cnt_q + CW'(1);
            end
        end

        if (MODE == DET_BOTH) begin
            mode_ok = 1'b1;
        end else if (MODE == DET_ONES) begin
            mode_ok = run_bit_d;
        end else if (MODE == DET_ZEROS) begin
            mode_ok = ~run_bit_d;
        end

        z_d = (run_cnt_d == RunLenC) && mode_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
            run_bit_q <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            run_bit_q <= run_bit_d;
            z_q       <= z_d;
        end
    end

    assign z      = z_q;
    assign states = {run_bit_q, run_cnt_q};

`ifdef RUN_DETECTOR_HIT_CNT_EN
    logic hit_inc;

    assign hit_inc = z_d & ~z_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_hits (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_inc),
        .count (hits)
    );
`else
    assign hits = '0;
`endif

endmodule

// File: tb/tb_run_detector_fsm.sv
// Bench for run_detector_fsm: four configurations share one stimulus stream and are checked
// every cycle against a sample-history model.
module tb_run_detector_fsm;

`ifdef RUN_DETECTOR_HIT_CNT_EN
    localparam bit HitEn = 1'b1;
`else
    localparam bit HitEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic w = 1'b0;

    logic       z0, z1, z2, z3;
    logic [3:0] st0, st1, st2;
    logic [2:0] st3;
    logic [7:0] h0, h1, h3;
    logic [1:0] h2;

    always #5 clk = ~clk;

    run_detector_fsm #(.RUN_LEN(4), .MODE(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .en(en), .w(w), .z(z0), .states(st0), .hits(h0));
    run_detector_fsm #(.RUN_LEN(4), .MODE(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .en(en), .w(w), .z(z1), .states(st1), .hits(h1));
    run_detector_fsm #(.RUN_LEN(4), .MODE(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .w(w), .z(z2), .states(st2), .hits(h2));
    run_detector_fsm #(.RUN_LEN(2), .MODE(2), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .en(en), .w(w), .z(z3), .states(st3), .hits(h3));

    int n_cmp = 0;
    int n_err = 0;

    // Model: every enabled sample since the last reset, plus per-config hit counts.
    bit hist[$];
    int exp_hits[4];
    bit prev_z[4];

    function automatic int rl_of(input int j);
        return (j == 3) ? 2 : 4;
    endfunction

    function automatic int md_of(input int j);
        case (j)
            1:       return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cntw_of(input int j);
        return (j == 2) ? 2 : 8;
    endfunction

    function automatic int trail();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1]) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit last_bit();
        return (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
    endfunction

    function automatic bit model_z(input int j);
        bit b = last_bit();
        bit ok = (md_of(j) == 0) || (md_of(j) == 1 && b) || (md_of(j) == 2 && !b);
        return (trail() >= rl_of(j)) && ok;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input bit b);
        if (r) begin
            hist.delete();
            for (int j = 0; j < 4; j++) begin
                exp_hits[j] = 0;
                prev_z[j]   = 1'b0;
            end
        end else if (e) begin
            hist.push_back(b);
            for (int j = 0; j < 4; j++) begin
                bit zn = model_z(j);
                if (zn && !prev_z[j] && exp_hits[j] < (1 << cntw_of(j)) - 1) exp_hits[j]++;
                prev_z[j] = zn;
            end
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 4; j++) begin
            logic [31:0] az, ast, ah;
            int t  = trail();
            int c  = (t < rl_of(j)) ? t : rl_of(j);
            int cw = $clog2(rl_of(j) + 1);
            int est = (int'(last_bit()) << cw) + c;
            case (j)
                0:       begin az = 32'(z0); ast = 32'(st0); ah = 32'(h0); end
                1:       begin az = 32'(z1); ast = 32'(st1); ah = 32'(h1); end
                2:       begin az = 32'(z2); ast = 32'(st2); ah = 32'(h2); end
                default: begin az = 32'(z3); ast = 32'(st3); ah = 32'(h3); end
            endcase
            check($sformatf("dut%0d.z", j), az, 32'(model_z(j)));
            check($sformatf("dut%0d.states", j), ast, 32'(est));
            check($sformatf("dut%0d.hits", j), ah, HitEn ? 32'(exp_hits[j]) : 32'd0);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit b);
        reset = r;
        en    = e;
        w     = b;
        @(posedge clk);
        model_update(r, e, b);
        #1;
        check_all();
    endtask

    initial begin
        bit b;

        // Reset state
        step(1, 0, 0);
        check("lit reset states", 32'(st0), 32'd0);
        check("lit reset z", 32'(z0), 32'd0);

        // Four ones, then three more, then a break (RUN_LEN=4, MODE 0)
        step(0, 1, 1);
        check("lit run1 states", 32'(st0), 32'h9);
        step(0, 1, 1);
        step(0, 1, 1);
        check("lit run3 z", 32'(z0), 32'd0);
        step(0, 1, 1);
        check("lit run4 states", 32'(st0), 32'hC);
        check("lit run4 z", 32'(z0), 32'd1);
        check("lit run4 hits", 32'(h0), HitEn ? 32'd1 : 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        check("lit saturated z", 32'(z0), 32'd1);
        step(0, 1, 0);
        check("lit break states", 32'(st0), 32'h1);
        check("lit break z", 32'(z0), 32'd0);

        // Ones-only mode ignores a zero run
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        check("lit mode1 zeros z", 32'(z1), 32'd0);
        check("lit mode1 zeros states", 32'(st1), 32'h4);
        for (int i = 0; i < 4; i++) step(0, 1, 1);
        check("lit mode1 ones z", 32'(z1), 32'd1);
        check("lit mode1 hits", 32'(h1), HitEn ? 32'd1 : 32'd0);

        // Enable gating: z rises only on the 4th enabled edge
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        check("lit en gated z", 32'(z0), 32'd0);
        step(0, 1, 1);
        check("lit en 4th z", 32'(z0), 32'd1);

        // Reset mid-run has priority over en
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        step(1, 1, 1);
        check("lit midreset states", 32'(st0), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        check("lit zeros run z", 32'(z0), 32'd1);

        // Five alternating runs saturate the 2-bit counter
        step(1, 0, 0);
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) step(0, 1, (r % 2) == 0);
        end
        check("lit sat hits", 32'(h2), HitEn ? 32'd3 : 32'd0);

        // Alternating stream never detects
        for (int i = 0; i < 8; i++) step(0, 1, i[0]);
        check("lit alternating z", 32'(z0), 32'd0);

        // Randomised stream with run-biased bits
        b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) b = ~b;
            step($urandom_range(59) == 0, $urandom_range(3) != 0, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
